// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR-based random generators:
// LFSR geometry, reset seed, and the draw FSM state encoding.
package rng_pkg;

  localparam int unsigned LFSR_W = 31;
  localparam int unsigned TAP_HI = 30;
  localparam int unsigned TAP_LO = 27;

  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 31'h44D5AFAB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    VALID = 2'd2
  } rng_state_e;

  // One Fibonacci step: shift left, feed back the XOR of the two taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr31_core.sv
// 31-bit Fibonacci LFSR with load and step controls.
// A zero load value is replaced by SEED so the register can never lock up.
module lfsr31_core
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              qzt_clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_state;

  // Load has priority over stepping; zero seeds fall back to SEED.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/uniform_range_gen.sv
// Uniform random integer generator over 0..RANGE_MAX using rejection
// sampling on a 31-bit LFSR, with req/valid/ready handshakes, seed reload
// and a bounded-retry fallback.
// Optional: define UNIFORM_RANGE_GEN_REJECT_CNT_EN to add the saturating
// reject_cnt / fallback_cnt statistics outputs.
module uniform_range_gen
  import rng_pkg::*;
#(
  parameter int unsigned       RANGE_MAX    = 9,
  parameter int unsigned       OUT_W        = 4,
  parameter int unsigned       MAX_TRIES    = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 31'h44D5AFAB
) (
  input  logic              qzt_clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
  ,
  output logic [15:0]       reject_cnt,
  output logic [7:0]        fallback_cnt
`endif
);

  localparam int unsigned K     = $clog2(RANGE_MAX + 1);
  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  rng_state_e        r_state;
  rng_state_e        w_state_nxt;
  logic [TRY_W-1:0]  r_try;
  logic [TRY_W-1:0]  w_try_nxt;
  logic [OUT_W-1:0]  r_out_data;
  logic [OUT_W-1:0]  w_data_nxt;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_req_ready;
  logic              w_step;
  logic [LFSR_W-1:0] w_lfsr;
  logic [OUT_W-1:0]  w_cand;
  logic              w_in_range;
  logic              w_last_try;
  logic [OUT_W-1:0]  w_fold;
  logic              w_lfsr_unused_c;

  lfsr31_core #(
    .SEED(DEFAULT_SEED)
  ) u_lfsr (
    .qzt_clk (qzt_clk),
    .rst_n   (rst_n),
    .step    (w_step),
    .load    (seed_load),
    .load_val(seed_in),
    .state   (w_lfsr)
  );

  // Candidate is the low K LFSR bits; out-of-range values fold down by RANGE_MAX+1.
  assign w_cand          = OUT_W'(w_lfsr[K-1:0]);
  assign w_in_range      = (w_cand <= OUT_W'(RANGE_MAX));
  assign w_fold          = w_cand - OUT_W'(RANGE_MAX + 1);
  assign w_last_try      = (r_try == TRY_W'(MAX_TRIES - 1));
  assign w_lfsr_unused_c = ^w_lfsr[LFSR_W-1:K];

  // Next-state, try counter, result capture and LFSR step request.
  always_comb begin
    w_state_nxt = r_state;
    w_try_nxt   = r_try;
    w_data_nxt  = r_out_data;
    w_step      = 1'b0;
    if (seed_load) begin
      w_state_nxt = IDLE;
      w_try_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            w_state_nxt = DRAW;
            w_try_nxt   = '0;
          end
        end
        DRAW: begin
          w_step = 1'b1;
          if (w_in_range) begin
            w_data_nxt  = w_cand;
            w_state_nxt = VALID;
          end else if (w_last_try) begin
            w_data_nxt  = w_fold;
            w_state_nxt = VALID;
          end else begin
            w_try_nxt = r_try + TRY_W'(1);
          end
        end
        VALID: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_try       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_try       <= w_try_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= (w_state_nxt == VALID);
      r_busy      <= (w_state_nxt == DRAW);
      r_req_ready <= (w_state_nxt == IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
  logic [15:0] r_reject_cnt;
  logic [7:0]  r_fallback_cnt;
  logic        w_reject_c;
  logic        w_fallback_c;

  assign w_reject_c   = (r_state == DRAW) && !seed_load && !w_in_range;
  assign w_fallback_c = w_reject_c && w_last_try;

  // Saturating statistics counters, cleared by reset and seed reload.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reject_cnt   <= '0;
      r_fallback_cnt <= '0;
    end else if (seed_load) begin
      r_reject_cnt   <= '0;
      r_fallback_cnt <= '0;
    end else begin
      if (w_reject_c && (r_reject_cnt != 16'hFFFF)) begin
        r_reject_cnt <= r_reject_cnt + 16'd1;
      end
      if (w_fallback_c && (r_fallback_cnt != 8'hFF)) begin
        r_fallback_cnt <= r_fallback_cnt + 8'd1;
      end
    end
  end

  assign reject_cnt   = r_reject_cnt;
  assign fallback_cnt = r_fallback_cnt;
`else
  // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_uniform_range_gen.sv
// Directed bench for uniform_range_gen: handshake latency, rejection,
// fallback, zero seed, back-pressure, seed reload / reset interruption and
// output distribution. Counter checks are built when
// UNIFORM_RANGE_GEN_REJECT_CNT_EN is defined.
module tb_uniform_range_gen;

  localparam logic [30:0] DEF_SEED = 31'h44D5AFAB;

  logic        qzt_clk = 1'b0;
  logic        rst_n;

  logic        a_seed_load, a_req_valid, a_out_ready;
  logic [30:0] a_seed_in;
  logic        a_req_ready, a_out_valid, a_busy;
  logic [3:0]  a_out_data;

  logic        b_seed_load, b_req_valid, b_out_ready;
  logic [30:0] b_seed_in;
  logic        b_req_ready, b_out_valid, b_busy;
  logic [3:0]  b_out_data;

`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
  logic [15:0] a_rej, b_rej;
  logic [7:0]  a_fb, b_fb;
`endif

  int checks = 0;
  int errors = 0;
  int hist[16];
  int draws;
  int cycles;

  always #5 qzt_clk = ~qzt_clk;

  uniform_range_gen #(
    .RANGE_MAX(9), .OUT_W(4), .MAX_TRIES(8), .DEFAULT_SEED(DEF_SEED)
  ) u_a (
    .qzt_clk  (qzt_clk),
    .rst_n    (rst_n),
    .seed_load(a_seed_load),
    .seed_in  (a_seed_in),
    .req_valid(a_req_valid),
    .req_ready(a_req_ready),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_data (a_out_data),
    .busy     (a_busy)
`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
    ,
    .reject_cnt  (a_rej),
    .fallback_cnt(a_fb)
`endif
  );

  uniform_range_gen #(
    .RANGE_MAX(9), .OUT_W(4), .MAX_TRIES(1), .DEFAULT_SEED(DEF_SEED)
  ) u_b (
    .qzt_clk  (qzt_clk),
    .rst_n    (rst_n),
    .seed_load(b_seed_load),
    .seed_in  (b_seed_in),
    .req_valid(b_req_valid),
    .req_ready(b_req_ready),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_data (b_out_data),
    .busy     (b_busy)
`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
    ,
    .reject_cnt  (b_rej),
    .fallback_cnt(b_fb)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge qzt_clk);
    #1;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst_n = 1'b0;
    a_seed_load = 0; a_seed_in = '0; a_req_valid = 0; a_out_ready = 0;
    b_seed_load = 0; b_seed_in = '0; b_req_valid = 0; b_out_ready = 0;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    tick();
    tick();

    // Reset values
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data",  32'(a_out_data),  32'd0);
    check("rst_busy",      32'(a_busy),      32'd0);
    check("rst_lfsr",      32'(u_a.u_lfsr.state), 32'(DEF_SEED));
    rst_n = 1'b1;
    tick();

    // Accept without rejection: seed 5 -> candidate 5
    a_seed_in = 31'h5; a_seed_load = 1; tick(); a_seed_load = 0;
    check("t1_lfsr", 32'(u_a.u_lfsr.state), 32'h5);
    a_req_valid = 1; tick(); a_req_valid = 0;
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_req_ready_draw", 32'(a_req_ready), 32'd0);
    check("t1_valid_early", 32'(a_out_valid), 32'd0);
    tick();
    check("t1_valid", 32'(a_out_valid), 32'd1);
    check("t1_data", 32'(a_out_data), 32'd5);
    check("t1_busy_valid", 32'(a_busy), 32'd0);
    a_out_ready = 1; tick(); a_out_ready = 0;
    check("t1_valid_clr", 32'(a_out_valid), 32'd0);
    check("t1_req_ready", 32'(a_req_ready), 32'd1);

    // One rejection: seed C -> 12 rejected, LFSR 0x18 -> 8
    a_seed_in = 31'hC; a_seed_load = 1; tick(); a_seed_load = 0;
    a_req_valid = 1; tick(); a_req_valid = 0;
    tick();
    check("t2_still_draw", 32'(a_busy), 32'd1);
    check("t2_valid_early", 32'(a_out_valid), 32'd0);
    check("t2_lfsr", 32'(u_a.u_lfsr.state), 32'h18);
    tick();
    check("t2_valid", 32'(a_out_valid), 32'd1);
    check("t2_data", 32'(a_out_data), 32'd8);
`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
    check("t2_reject_cnt", 32'(a_rej), 32'd1);
    check("t2_fallback_cnt", 32'(a_fb), 32'd0);
`endif
    a_out_ready = 1; tick(); a_out_ready = 0;

    // Zero seed -> default seed; B rejected, 7 accepted; then back-pressure
    a_seed_in = '0; a_seed_load = 1; tick(); a_seed_load = 0;
    check("t3_zero_seed", 32'(u_a.u_lfsr.state), 32'(DEF_SEED));
`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
    check("t3_reject_clr", 32'(a_rej), 32'd0);
`endif
    a_req_valid = 1; tick(); tick(); tick();
    check("t3_valid", 32'(a_out_valid), 32'd1);
    check("t3_data", 32'(a_out_data), 32'd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", 32'(a_out_valid), 32'd1);
      check("t3_hold_data", 32'(a_out_data), 32'd7);
      check("t3_hold_req_ready", 32'(a_req_ready), 32'd0);
    end
    check("t3_lfsr_frozen", 32'(u_a.u_lfsr.state), 32'h1356BEAF);
    a_req_valid = 0; a_out_ready = 1; tick(); a_out_ready = 0;
    check("t3_release", 32'(a_out_valid), 32'd0);
    check("t3_req_ready", 32'(a_req_ready), 32'd1);

    // seed_load together with req_valid: request ignored
    a_seed_in = 31'h5; a_seed_load = 1; a_req_valid = 1; tick();
    a_seed_load = 0; a_req_valid = 0;
    check("t4_busy", 32'(a_busy), 32'd0);
    check("t4_req_ready", 32'(a_req_ready), 32'd1);
    check("t4_lfsr", 32'(u_a.u_lfsr.state), 32'h5);

    // seed_load during DRAW drops the draw
    a_seed_in = 31'hC; a_seed_load = 1; tick(); a_seed_load = 0;
    a_req_valid = 1; tick(); a_req_valid = 0;
    check("t5_in_draw", 32'(a_busy), 32'd1);
    a_seed_in = 31'h5; a_seed_load = 1; tick(); a_seed_load = 0;
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_req_ready", 32'(a_req_ready), 32'd1);
    check("t5_lfsr", 32'(u_a.u_lfsr.state), 32'h5);
    tick();
    check("t5_dropped", 32'(a_out_valid), 32'd0);

    // Asynchronous reset during DRAW
    a_seed_in = 31'hC; a_seed_load = 1; tick(); a_seed_load = 0;
    a_req_valid = 1; tick(); a_req_valid = 0;
    check("t6_in_draw", 32'(a_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(a_out_valid), 32'd0);
    check("t6_rst_busy", 32'(a_busy), 32'd0);
    check("t6_rst_req_ready", 32'(a_req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_lfsr", 32'(u_a.u_lfsr.state), 32'(DEF_SEED));

    // Fallback with MAX_TRIES=1: seed F -> 15 rejected -> 5
    b_seed_in = 31'hF; b_seed_load = 1; tick(); b_seed_load = 0;
    b_req_valid = 1; tick(); b_req_valid = 0;
    tick();
    check("t7_valid", 32'(b_out_valid), 32'd1);
    check("t7_data", 32'(b_out_data), 32'd5);
`ifdef UNIFORM_RANGE_GEN_REJECT_CNT_EN
    check("t7_reject_cnt", 32'(b_rej), 32'd1);
    check("t7_fallback_cnt", 32'(b_fb), 32'd1);
`endif
    b_out_ready = 1; tick(); b_out_ready = 0;

    // Distribution: 10000 draws from the default seed
    draws = 0;
    cycles = 0;
    a_req_valid = 1; a_out_ready = 1;
    while (draws < 10000 && cycles < 60000) begin
      tick();
      cycles++;
      if (a_out_valid) begin
        hist[a_out_data]++;
        draws++;
      end
    end
    a_req_valid = 0; a_out_ready = 0;
    check("dist_draws", 32'(draws), 32'd10000);
    for (int v = 0; v < 10; v++) begin
      check($sformatf("dist_bin%0d_in_band(count=%0d)", v, hist[v]),
            32'((hist[v] >= 850) && (hist[v] <= 1150)), 32'd1);
    end
    for (int v = 10; v < 16; v++) begin
      check($sformatf("dist_bin%0d_empty", v), 32'(hist[v]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
